// File: rtl/fir_result_serializer.sv
// rtl/fir_result_serializer.sv - serializes signed FIR results into MSB-first byte stream
module fir_result_serializer #(
    parameter int NUM_OF_TAPS = 3,
    parameter int INPUT_WIDTH = 8,
    parameter int COEF_WIDTH  = 8,
    localparam int RESULT_WIDTH = INPUT_WIDTH + COEF_WIDTH + $clog2(NUM_OF_TAPS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [RESULT_WIDTH-1:0] result_data,
    input  logic                    result_data_flag,
    output logic [7:0]              out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last,
    output logic                    overflow,
    output logic                    busy
);
    localparam int NUM_BYTES = (RESULT_WIDTH + 7) / 8;
    localparam int EXT_WIDTH = NUM_BYTES * 8;
    localparam int CNT_WIDTH = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(NUM_BYTES - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                 state_q, state_d;
    logic [EXT_WIDTH-1:0]   shift_q, shift_d;
    logic [EXT_WIDTH-1:0]   pend_q, pend_d;
    logic [EXT_WIDTH-1:0]   ext_in;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   pend_valid_q, pend_valid_d;
    logic                   overflow_q, overflow_d;
    logic                   out_valid_q, out_last_q, busy_q;
    logic                   xfer, is_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            pend_q       <= '0;
            cnt_q        <= '0;
            pend_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            pend_q       <= pend_d;
            cnt_q        <= cnt_d;
            pend_valid_q <= pend_valid_d;
            overflow_q   <= overflow_d;
            // Output flags are registered from next-state so they align with shift_q
            out_valid_q  <= (state_d == SEND);
            out_last_q   <= (state_d == SEND) && (cnt_d == LAST_IDX);
            busy_q       <= (state_d == SEND) || pend_valid_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        pend_d       = pend_q;
        cnt_d        = cnt_q;
        pend_valid_d = pend_valid_q;
        overflow_d   = overflow_q;
        ext_in       = EXT_WIDTH'($signed(result_data));
        xfer         = out_valid_q && out_ready;
        is_last      = (cnt_q == LAST_IDX);

        case (state_q)
            IDLE: begin
                if (result_data_flag) begin
                    shift_d = ext_in;
                    cnt_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (xfer && is_last) begin
                    cnt_d = '0;
                    if (pend_valid_q) begin
                        // Pending result goes out next with no bubble; a same-cycle flag refills pending
                        shift_d = pend_q;
                        if (result_data_flag) begin
                            pend_d = ext_in;
                        end else begin
                            pend_valid_d = 1'b0;
                        end
                    end else if (result_data_flag) begin
                        shift_d = ext_in;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    if (xfer) begin
                        shift_d = shift_q << 8;
                        cnt_d   = cnt_q + CNT_WIDTH'(1);
                    end
                    if (result_data_flag) begin
                        if (!pend_valid_q) begin
                            pend_d       = ext_in;
                            pend_valid_d = 1'b1;
                        end else begin
                            overflow_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign out_data  = shift_q[EXT_WIDTH-1 -: 8];
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign overflow  = overflow_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_fir_result_serializer.sv
// tb/tb_fir_result_serializer.sv - scoreboard bench for fir_result_serializer
module tb_fir_result_serializer;
    localparam int RW = 18;
    localparam int NB = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [RW-1:0] result_data = '0;
    logic          result_data_flag = 1'b0;
    logic [7:0]    out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          out_last;
    logic          overflow;
    logic          busy;

    fir_result_serializer dut (
        .clk(clk), .rst_n(rst_n), .result_data(result_data),
        .result_data_flag(result_data_flag), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [8:0] exp_q[$];       // {last, byte}
    int         outstanding = 0; // results accepted but not fully sent
    logic       exp_ovf = 1'b0;
    logic       done = 1'b0;     // a result's final byte transferred this cycle
    logic       prev_stall = 1'b0;
    logic [8:0] prev_out = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the signed value, written as two's complement over NB bytes, MSB first
    task automatic push_result(input logic [RW-1:0] d);
        int v;
        v = int'(d);
        if (v >= (1 << (RW - 1))) v -= (1 << RW);
        for (int b = NB - 1; b >= 0; b--)
            exp_q.push_back({(b == 0), 8'(v >>> (8 * b))});
    endtask

    // Monitor: checks status against model, byte stability under stall, and pops the scoreboard
    always @(negedge clk) begin
        logic [8:0] e;
        done = 1'b0;
        if (rst_n) begin
            chk("out_valid", out_valid, outstanding > 0);
            chk("busy", busy, outstanding > 0);
            chk("overflow", overflow, exp_ovf);
            if (prev_stall) chk("hold", {out_valid, out_last, out_data}, {1'b1, prev_out});
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_byte", {out_last, out_data}, 9'h1ff);
                end else begin
                    e = exp_q.pop_front();
                    chk("byte", {out_last, out_data}, e);
                    done = e[8];
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = {out_last, out_data};
        end else begin
            prev_stall = 1'b0;
        end
    end

    // One cycle: inputs applied after posedge, model updated just after the monitor at negedge
    task automatic step(input logic f, input logic [RW-1:0] d, input logic r);
        result_data_flag = f;
        result_data      = d;
        out_ready        = r;
        @(negedge clk);
        #1;
        if (f) begin
            if (outstanding - int'(done) < 2) begin
                push_result(d);
                outstanding++;
            end else begin
                exp_ovf = 1'b1;
            end
        end
        if (done) outstanding--;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while (outstanding > 0 && n < 200) begin
            step(1'b0, '0, 1'b1);
            n++;
        end
        step(1'b0, '0, 1'b1);
        chk("drain_timeout", outstanding, 0);
        chk("queue_empty", exp_q.size(), 0);
    endtask

    task automatic check_reset_outputs();
        chk("rst_out_data", out_data, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_busy", busy, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs();
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // positive value
        step(1'b1, 18'h01234, 1'b1);
        drain();
        // negative value
        step(1'b1, 18'h2ABCD, 1'b1);
        drain();
        // backpressure after first byte
        step(1'b1, 18'h2ABCD, 1'b1);
        repeat (5) step(1'b0, '0, 1'b0);
        drain();
        // back-to-back, no bubble
        step(1'b1, 18'h01234, 1'b1);
        step(1'b1, 18'h2ABCD, 1'b1);
        drain();
        // overflow: third result dropped while stalled
        step(1'b1, 18'h00001, 1'b0);
        step(1'b1, 18'h00002, 1'b0);
        step(1'b1, 18'h00003, 1'b0);
        repeat (3) step(1'b0, '0, 1'b0);
        drain();
        // reset mid-result after byte 12
        step(1'b1, 18'h01234, 1'b1);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        exp_q.delete();
        outstanding = 0;
        exp_ovf = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b1, 18'h2ABCD, 1'b1);
        drain();

        // randomized traffic
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) == 0, RW'($urandom), $urandom_range(0, 3) != 0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
